uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Purpose : byte FIFO that feeds a UART transmitter, with a one-cycle send pulse.
// Latency : a byte pushed into an empty FIFO while the FSM is idle and the
//           transmitter is free raises wr_en on the next rising edge.
// Backpr. : the host sees full; a push while full (with no pop in the same
//           cycle) is dropped and, when UART_TX_FIFO_OVF_EN is defined,
//           sets the sticky ovf flag.
//
// Build macro: UART_TX_FIFO_OVF_EN enables the sticky overflow flag. Without
// it, ovf is tied low and ovf_clr is ignored. The port list is the same in
// both builds.
//
// Ports:
//   sys_clk    in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   push       in   host write strobe, one byte per cycle
//   push_data  in   byte written when push=1
//   full       out  FIFO holds DEPTH bytes
//   empty      out  FIFO holds no bytes
//   level      out  bytes queued, 0..DEPTH
//   ovf        out  sticky overflow flag
//   ovf_clr    in   clears ovf
//   wr_data    out  byte presented to the transmitter
//   wr_en      out  one-cycle send pulse
//   wr_busy    in   transmitter busy, already synchronized to sys_clk
//   tx_idle    out  FSM idle and FIFO empty
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic [7:0]    wr_data,
  output logic          wr_en,
  input  logic          wr_busy,
  output logic          tx_idle
);

  localparam int TW = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(BUSY_TIMEOUT);
  localparam logic [AW:0]   MSB_ONLY    = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   PTR_ONE     = (AW+1)'(1);
  localparam logic [TW-1:0] CNT_ONE     = TW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_ACK,
    S_DRAIN
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [TW-1:0] to_cnt;

  logic          pop;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          push_ok;
  logic          drop;

  // Pointers carry one extra MSB so full and empty are distinguishable
  // without a separate count register.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == MSB_ONLY);
  assign level   = wr_ptr - rd_ptr;
  assign tx_idle = (state == S_IDLE) && empty;

  // A pop in the same cycle frees the head slot, so a push into a full FIFO
  // is still accepted then. The write lands in the slot being read, and the
  // read sees the old contents because both happen at the same edge.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and outputs
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    wr_en     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !wr_busy) begin
          pop       = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        wr_en     = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = S_ACK;
      end
      S_ACK: begin
        // If busy never rises, the byte is assumed sent once the timeout
        // expires, so a missing busy handshake cannot stall the queue.
        if (wr_busy) begin
          state_nxt = S_DRAIN;
        end else if (to_cnt == TIMEOUT_VAL) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!wr_busy) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read and write pointers
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage is not cleared on reset; the pointers alone define contents.
  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // wr_data holds the byte loaded at the last pop until the next pop.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_data <= 8'h00;
    end else if (pop) begin
      wr_data <= mem[rd_ptr[AW-1:0]];
    end
  end

  // Timeout counter for the busy acknowledge
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (cnt_clr) begin
      to_cnt <= '0;
    end else if (cnt_inc) begin
      to_cnt <= to_cnt + CNT_ONE;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  // Sticky overflow: a drop wins over a clear in the same cycle.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = ^{ovf_clr, drop};
  assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Purpose : self-checking bench for uart_tx_fifo: directed scenarios plus
//           randomized fill/drain rounds against a queue reference model.
// Latency : n/a (testbench)
// Backpr. : the bench plays the transmitter, answering each wr_en with a
//           randomized busy pulse.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef UART_TX_FIFO_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          sys_clk   = 1'b0;
  logic          reset     = 1'b1;
  logic          push      = 1'b0;
  logic [7:0]    push_data = 8'h00;
  logic          ovf_clr   = 1'b0;
  logic          wr_busy   = 1'b0;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          ovf;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          tx_idle;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [7:0]    exp_q[$];

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .BUSY_TIMEOUT(15)) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .wr_busy   (wr_busy),
    .tx_idle   (tx_idle)
  );

  always #5 sys_clk = ~sys_clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_en(input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (wr_en === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_wr_en", 32'(found), 32'd1);
  endtask

  // Acts as the transmitter: every wr_en pulse is compared against the model
  // queue and answered with a short delay followed by a busy pulse.
  task automatic drain(input int budget);
    int         cyc;
    int         d;
    int         k;
    logic [7:0] e;
    cyc = 0;
    while ((exp_q.size() != 0 || tx_idle !== 1'b1) && cyc < budget) begin
      if (wr_en === 1'b1) begin
        chk("send_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = 8'h00;
        chk("tx_order", 32'(wr_data), 32'(e));
        d = int'($urandom_range(0, 3));
        k = int'($urandom_range(1, 5));
        wr_busy = 1'b0;
        tick(); cyc++;
        chk("single_pulse", 32'(wr_en), 32'd0);
        for (int i = 0; i < d; i++) begin
          tick(); cyc++;
          chk("no_en_wait", 32'(wr_en), 32'd0);
        end
        wr_busy = 1'b1;
        for (int i = 0; i < k; i++) begin
          tick(); cyc++;
          chk("no_en_busy", 32'(wr_en), 32'd0);
        end
        wr_busy = 1'b0;
      end else begin
        tick(); cyc++;
      end
    end
    chk("drain_done", 32'(exp_q.size() == 0 && tx_idle === 1'b1), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         seen;
    bit         exp_ovf;
    int         n;
    int         sent;
    logic [7:0] b;

    // Reset, with push and ovf_clr asserted to show reset wins.
    reset = 1'b1; push = 1'b1; push_data = 8'hAA; ovf_clr = 1'b1; wr_busy = 1'b0;
    tick(); tick();
    reset = 1'b0; push = 1'b0; ovf_clr = 1'b0;
    chk("rst_empty",   32'(empty),   32'd1);
    chk("rst_full",    32'(full),    32'd0);
    chk("rst_level",   32'(level),   32'd0);
    chk("rst_tx_idle", 32'(tx_idle), 32'd1);
    chk("rst_wr_en",   32'(wr_en),   32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'h00);
    chk("rst_ovf",     32'(ovf),     32'd0);

    // Single byte: wr_en one edge after the push edge.
    push = 1'b1; push_data = 8'h41;
    tick();
    push = 1'b0;
    chk("lat_level1", 32'(level), 32'd1);
    chk("lat_no_en",  32'(wr_en), 32'd0);
    tick();
    chk("lat_wr_en",   32'(wr_en),   32'd1);
    chk("lat_wr_data", 32'(wr_data), 32'h41);
    chk("lat_level0",  32'(level),   32'd0);

    // Busy never rises: 16 cycles in S_ACK, then the queued byte goes out.
    push = 1'b1; push_data = 8'h42;
    tick();
    push = 1'b0;
    chk("ack_no_en", 32'(wr_en), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      seen = seen | wr_en;
    end
    chk("timeout_quiet", 32'(seen), 32'd0);
    tick();
    chk("timeout_next_en",   32'(wr_en),   32'd1);
    chk("timeout_next_data", 32'(wr_data), 32'h42);
    for (int i = 0; i < 40 && tx_idle !== 1'b1; i++) tick();
    chk("timeout_idle", 32'(tx_idle), 32'd1);

    // Fill to full while busy, then overflow and clear.
    wr_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      push = 1'b1; push_data = 8'(8'h10 + i);
      tick();
    end
    push = 1'b0;
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_empty", 32'(empty), 32'd0);
    push = 1'b1; push_data = 8'hEE;
    tick();
    push = 1'b0;
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_flag",  32'(ovf),   32'(OVF_EN));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);

    // Push and pop in the same cycle while full.
    push = 1'b1; push_data = 8'h20; wr_busy = 1'b0;
    tick();
    push = 1'b0;
    chk("pp_level",   32'(level),   32'd16);
    chk("pp_wr_en",   32'(wr_en),   32'd1);
    chk("pp_wr_data", 32'(wr_data), 32'h10);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'h10 + i));
    exp_q.push_back(8'h20);
    drain(60 * DEPTH);

    // Reset during S_DRAIN with 5 bytes queued.
    push = 1'b1; push_data = 8'h55; wr_busy = 1'b0;
    tick();
    push = 1'b0;
    wait_en(10);
    wr_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; push_data = 8'(8'h60 + i);
      tick();
    end
    push = 1'b0;
    chk("drain_level5", 32'(level), 32'd5);
    reset = 1'b1; push = 1'b1; push_data = 8'h77; ovf_clr = 1'b1;
    tick();
    reset = 1'b0; push = 1'b0; ovf_clr = 1'b0; wr_busy = 1'b0;
    chk("mid_rst_wr_en",   32'(wr_en),   32'd0);
    chk("mid_rst_wr_data", 32'(wr_data), 32'h00);
    chk("mid_rst_empty",   32'(empty),   32'd1);
    chk("mid_rst_tx_idle", 32'(tx_idle), 32'd1);
    chk("mid_rst_level",   32'(level),   32'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      seen = seen | wr_en;
    end
    chk("mid_rst_quiet", 32'(seen), 32'd0);

    // Randomized rounds: fill while busy (with possible drops), then drain.
    // Total traffic wraps the pointers several times.
    exp_q.delete();
    for (int r = 0; r < 10; r++) begin
      wr_busy = 1'b1;
      exp_ovf = 1'b0;
      n = int'($urandom_range(DEPTH / 2, DEPTH + 3));
      sent = 0;
      while (sent < n) begin
        if ($urandom_range(0, 3) != 0) begin
          b = 8'($urandom);
          push = 1'b1; push_data = b;
          if (exp_q.size() < DEPTH) exp_q.push_back(b);
          else if (OVF_EN)          exp_ovf = 1'b1;
          sent++;
        end else begin
          push = 1'b0;
        end
        tick();
      end
      push = 1'b0;
      chk("rnd_level", 32'(level), 32'(exp_q.size()));
      chk("rnd_full",  32'(full),  32'(exp_q.size() == DEPTH));
      chk("rnd_empty", 32'(empty), 32'(exp_q.size() == 0));
      chk("rnd_ovf",   32'(ovf),   32'(exp_ovf));
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("rnd_ovf_clr", 32'(ovf), 32'd0);
      wr_busy = 1'b0;
      drain(60 * DEPTH);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
